// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first.
// The operand set is latched on accept and the result is held until it is popped.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_idx;

  logic [31:0]      w_shift;
  logic [CHUNK-1:0] w_a_k;
  logic [CHUNK-1:0] w_b_k;
  logic [CHUNK-1:0] w_s_k;
  logic [CHUNK:0]   w_c;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  always_comb begin
    w_shift    = 32'(r_idx) * 32'(CHUNK);
    w_a_k      = CHUNK'(r_a >> w_shift);
    w_b_k      = CHUNK'(r_b >> w_shift);
    w_mask     = WIDTH'({CHUNK{1'b1}}) << w_shift;
    w_sum_next = (r_sum & ~w_mask) | (WIDTH'(w_s_k) << w_shift);
    w_last     = (r_idx == IDX_W'(N - 1));
  end

  // Ripple carry through the current chunk.
  assign w_c[0] = r_carry;
  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_ripple
      assign w_s_k[gi]   = w_a_k[gi] ^ w_b_k[gi] ^ w_c[gi];
      assign w_c[gi+1]   = (w_a_k[gi] & w_b_k[gi]) | (w_c[gi] & (w_a_k[gi] ^ w_b_k[gi]));
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_carry <= cin ^ sub;
          r_idx   <= '0;
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_c[CHUNK];
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_cout      <= w_c[CHUNK];
            // a ^ b ^ sum at the MSB recovers the carry into the MSB.
            r_ovf       <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s_k[CHUNK-1] ^ w_c[CHUNK];
            r_out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
